// File: rtl/hub75_scan_ctrl_pkg.sv
// Shared definitions for the HUB75 scan controller: FSM state encoding and
// an elaboration-time clog2 helper.
package hub75_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_BLANK   = 3'd3,
        ST_LATCH   = 3'd4,
        ST_DISPLAY = 3'd5
    } scan_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hub75_scan_ctrl_bcm_timer.sv
// BCM display timer: loads ON_BASE<<plane, counts down, and flags the final
// display cycle so the scan FSM can leave DISPLAY on time.
module hub75_scan_ctrl_bcm_timer
    import hub75_scan_ctrl_pkg::*;
#(
    parameter int ON_BASE = 8,
    parameter int PLANES  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [clog2(PLANES)-1:0]   plane,
    output logic                       done
);

    localparam int CNT_W = clog2(ON_BASE << (PLANES - 1)) + 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(ON_BASE << plane);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 panel scan sequencer: fetches and shifts one row per BCM plane,
// blanks, latches, then displays for a binary-weighted interval.
module hub75_scan_ctrl
    import hub75_scan_ctrl_pkg::*;
#(
    parameter int COLS      = 64,
    parameter int ROW_AW    = 4,
    parameter int PLANES    = 4,
    parameter int ON_BASE   = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          en,
    output logic [clog2(PLANES)+ROW_AW+clog2(COLS)-1:0]   rd_addr,
    input  logic [5:0]                                    rd_data,
    output logic [5:0]                                    rgb,
    output logic                                          sclk,
    output logic                                          lat,
    output logic                                          oe_n,
    output logic [ROW_AW-1:0]                             row,
    output logic                                          frame_start
);

    localparam int PLANE_W = clog2(PLANES);
    localparam int COL_W   = clog2(COLS);
    localparam int BLK_W   = clog2(BLANK_CYC) + 1;

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
    localparam logic [BLK_W-1:0]   BLANK_LAST = BLK_W'(BLANK_CYC - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(PLANES - 1);

    scan_state_t        state;
    logic [PLANE_W-1:0] plane;
    logic [ROW_AW-1:0]  row_cnt;
    logic [COL_W-1:0]   col;
    logic               phase_b;
    logic [BLK_W-1:0]   blank_cnt;
    logic               disp_done;

    logic               plane_wrap;
    logic [PLANE_W-1:0] next_plane;
    logic [ROW_AW-1:0]  next_row;
    logic [COL_W-1:0]   col_next;

    always_comb begin
        plane_wrap = (plane == PLANE_LAST);
        next_plane = plane_wrap ? '0 : plane + PLANE_W'(1);
        next_row   = plane_wrap ? row_cnt + ROW_AW'(1) : row_cnt;
        col_next   = col + COL_W'(1);
    end

    hub75_scan_ctrl_bcm_timer #(
        .ON_BASE (ON_BASE),
        .PLANES  (PLANES)
    ) bcm_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (state == ST_LATCH),
        .plane (plane),
        .done  (disp_done)
    );

    // NOTE: every state and output register is assigned with <= so all of them
    // update together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            plane       <= '0;
            row_cnt     <= '0;
            col         <= '0;
            phase_b     <= 1'b0;
            blank_cnt   <= '0;
            rd_addr     <= '0;
            rgb         <= '0;
            sclk        <= 1'b0;
            lat         <= 1'b0;
            oe_n        <= 1'b1;
            row         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        plane       <= '0;
                        row_cnt     <= '0;
                        col         <= '0;
                        rd_addr     <= '0;
                        frame_start <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    phase_b <= 1'b0;
                    state   <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    if (!phase_b) begin
                        // Capture data for this column and request the next one
                        // so it returns in time for the following phase A.
                        rgb     <= rd_data;
                        sclk    <= 1'b1;
                        phase_b <= 1'b1;
                        if (col != COL_LAST) rd_addr <= {plane, row_cnt, col_next};
                    end else begin
                        sclk    <= 1'b0;
                        phase_b <= 1'b0;
                        if (col == COL_LAST) begin
                            col       <= '0;
                            blank_cnt <= '0;
                            if (plane == '0) row <= row_cnt;
                            state     <= ST_BLANK;
                        end else begin
                            col <= col_next;
                        end
                    end
                end

                ST_BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        lat   <= 1'b1;
                        state <= ST_LATCH;
                    end else begin
                        blank_cnt <= blank_cnt + BLK_W'(1);
                    end
                end

                ST_LATCH: begin
                    lat   <= 1'b0;
                    oe_n  <= 1'b0;
                    state <= ST_DISPLAY;
                end

                ST_DISPLAY: begin
                    if (disp_done) begin
                        oe_n    <= 1'b1;
                        plane   <= next_plane;
                        row_cnt <= next_row;
                        if (en) begin
                            rd_addr     <= {next_plane, next_row, {COL_W{1'b0}}};
                            frame_start <= (next_plane == '0) && (next_row == '0);
                            state       <= ST_FETCH;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Randomized self-checking bench for hub75_scan_ctrl, compared cycle by cycle
// against a plane-schedule model derived from the panel timing rules.
module tb_hub75_scan_ctrl;

    localparam int COLS      = 4;
    localparam int ROW_AW    = 2;
    localparam int PLANES    = 2;
    localparam int ON_BASE   = 2;
    localparam int BLANK_CYC = 2;
    localparam int ROWS      = 1 << ROW_AW;
    localparam int PLANE_W   = $clog2(PLANES);
    localparam int COL_W     = $clog2(COLS);
    localparam int ADDR_W    = PLANE_W + ROW_AW + COL_W;

    logic              clk;
    logic              rst;
    logic              en;
    logic [ADDR_W-1:0] rd_addr;
    logic [5:0]        rd_data;
    logic [5:0]        rgb;
    logic              sclk;
    logic              lat;
    logic              oe_n;
    logic [ROW_AW-1:0] row;
    logic              frame_start;

    hub75_scan_ctrl #(
        .COLS      (COLS),
        .ROW_AW    (ROW_AW),
        .PLANES    (PLANES),
        .ON_BASE   (ON_BASE),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rgb         (rgb),
        .sclk        (sclk),
        .lat         (lat),
        .oe_n        (oe_n),
        .row         (row),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame buffer with one cycle of read latency.
    logic [5:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) rd_data <= mem[rd_addr];

    // Cycle stamps of every frame_start pulse.
    int cyc = 0;
    int fs_q[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_start) fs_q.push_back(cyc);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model position: plane and row about to be fetched, and the row pins.
    int p_m   = 0;
    int r_m   = 0;
    int row_m = 0;

    function automatic int plane_period(input int b);
        return 1 + 2 * COLS + BLANK_CYC + 1 + (ON_BASE << b);
    endfunction

    function automatic int frame_period();
        int s;
        s = 0;
        for (int b = 0; b < PLANES; b++) s += plane_period(b);
        return ROWS * s;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int p, input int r, input int c);
        return {PLANE_W'(p), ROW_AW'(r), COL_W'(c)};
    endfunction

    function automatic logic [31:0] ctrl_obs();
        return 32'({frame_start, sclk, lat, oe_n, row});
    endfunction

    function automatic logic [31:0] ctrl_exp(input bit fs, input bit sc, input bit lt,
                                             input bit oe, input int rw);
        return 32'({fs, sc, lt, oe, ROW_AW'(rw)});
    endfunction

    task automatic check_reset_values();
        check("rst_ctrl", ctrl_obs(), ctrl_exp(1'b0, 1'b0, 1'b0, 1'b1, 0));
        check("rst_addr", 32'(rd_addr), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
    endtask

    // One full plane starting at the FETCH cycle. en becomes en_after at phase A
    // of column sw_col; rst_disp >= 0 pulses reset during that display cycle.
    task automatic run_plane(input bit en_after, input int sw_col, input int rst_disp,
                             output bit was_reset);
        int n_disp;
        n_disp    = ON_BASE << p_m;
        was_reset = 1'b0;

        @(negedge clk);
        check("fetch_ctrl", ctrl_obs(), ctrl_exp(p_m == 0 && r_m == 0, 1'b0, 1'b0, 1'b1, row_m));
        check("fetch_addr", 32'(rd_addr), 32'(addr_of(p_m, r_m, 0)));

        for (int c = 0; c < COLS; c++) begin
            @(negedge clk);
            if (c == sw_col) en = en_after;
            check("shift_a_ctrl", ctrl_obs(), ctrl_exp(1'b0, 1'b0, 1'b0, 1'b1, row_m));
            check("shift_a_addr", 32'(rd_addr), 32'(addr_of(p_m, r_m, c)));
            @(negedge clk);
            check("shift_b_ctrl", ctrl_obs(), ctrl_exp(1'b0, 1'b1, 1'b0, 1'b1, row_m));
            check("shift_b_rgb", 32'(rgb), 32'(mem[addr_of(p_m, r_m, c)]));
        end

        if (p_m == 0) row_m = r_m;
        for (int k = 0; k < BLANK_CYC; k++) begin
            @(negedge clk);
            check("blank", ctrl_obs(), ctrl_exp(1'b0, 1'b0, 1'b0, 1'b1, row_m));
        end
        @(negedge clk);
        check("latch", ctrl_obs(), ctrl_exp(1'b0, 1'b0, 1'b1, 1'b1, row_m));

        for (int k = 0; k < n_disp; k++) begin
            @(negedge clk);
            check("display", ctrl_obs(), ctrl_exp(1'b0, 1'b0, 1'b0, 1'b0, row_m));
            if (k == rst_disp) begin
                rst = 1'b1;
                @(negedge clk);
                check_reset_values();
                rst       = 1'b0;
                en        = 1'b1;
                p_m       = 0;
                r_m       = 0;
                row_m     = 0;
                was_reset = 1'b1;
                return;
            end
        end

        p_m++;
        if (p_m == PLANES) begin
            p_m = 0;
            r_m = (r_m + 1) % ROWS;
        end
    endtask

    task automatic idle_then_start(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("idle", ctrl_obs(), ctrl_exp(1'b0, 1'b0, 1'b0, 1'b1, row_m));
        end
        en  = 1'b1;
        p_m = 0;
        r_m = 0;
    endtask

    initial begin
        bit was_rst;
        bit drop;
        int sw;
        int rd;
        int fs_base;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = {i[0], 5'b0};

        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        idle_then_start(2);

        // Three uninterrupted frames: rows wrap and frame_start spacing.
        fs_base = fs_q.size();
        for (int k = 0; k < PLANES * ROWS * 3; k++) begin
            if (k == PLANES) begin
                for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 6'($urandom);
            end
            run_plane(1'b1, 0, -1, was_rst);
        end
        check("fs_pulses", 32'(fs_q.size() - fs_base), 32'd3);
        if (fs_q.size() - fs_base >= 3) begin
            check("frame_period_0", 32'(fs_q[fs_base+1] - fs_q[fs_base]), 32'(frame_period()));
            check("frame_period_1", 32'(fs_q[fs_base+2] - fs_q[fs_base+1]), 32'(frame_period()));
        end

        // Random enable drops and occasional mid-display resets.
        for (int it = 0; it < 60; it++) begin
            drop = ($urandom_range(0, 3) == 0);
            sw   = $urandom_range(0, COLS - 1);
            rd   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, (ON_BASE << p_m) - 1) : -1;
            run_plane(!drop, sw, rd, was_rst);
            if (!was_rst && drop) idle_then_start($urandom_range(1, 4));
            if (it % 16 == 15) begin
                for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 6'($urandom);
            end
        end

        // en dropped during SHIFT of row 1 plane 1; restart from frame start.
        for (int k = 0; k < PLANES * ROWS && !(p_m == 1 && r_m == 1); k++)
            run_plane(1'b1, 0, -1, was_rst);
        run_plane(1'b0, 1, -1, was_rst);
        idle_then_start(3);
        run_plane(1'b1, 0, -1, was_rst);

        // Reset during plane 1 display, then resume.
        run_plane(1'b1, 0, 1, was_rst);
        run_plane(1'b1, 0, -1, was_rst);
        run_plane(1'b1, 0, -1, was_rst);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
